// File: rtl/sync_gen_ctrl.sv
// sync_gen_ctrl: one-shot / periodic sync pulse sequencer.
// Software or external trigger, abortable, with pulse counter.
module sync_gen_ctrl #(
  parameter int PERIOD_W   = 32,
  parameter int SYNC_WIDTH = 1,
  parameter int CNT_W      = 16
) (
  input  logic                user_clk,
  input  logic                user_rst,
  input  logic [31:0]         ctrl_word,
  input  logic [PERIOD_W-1:0] period,
  input  logic                ext_sync_in,
  output logic                sync_out,
  output logic                busy,
  output logic                waiting,
  output logic [CNT_W-1:0]    sync_count
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_EXT = 2'd1;
  localparam logic [1:0] FIRE     = 2'd2;
  localparam logic [1:0] PERIODIC = 2'd3;

  localparam logic [PERIOD_W-1:0] P_MIN =
    PERIOD_W'(SYNC_WIDTH + 1);
  localparam logic [PERIOD_W-1:0] P_ONE = PERIOD_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [7:0] W_LAST = 8'(SYNC_WIDTH);

  logic                arm;
  logic                src;
  logic                per_in;
  logic                abort;
  logic                unused_ctrl;
  logic                arm_q;
  logic                arm_edge;
  logic                s1, s2, s3;
  logic                ext_edge;
  logic [1:0]          state;
  logic                per_mode;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] pcnt;
  logic [PERIOD_W-1:0] pcnt_inc;
  logic [PERIOD_W-1:0] peff;
  logic [PERIOD_W-1:0] peff_m1;
  logic                hit;
  logic [7:0]          wcnt;

  assign arm         = ctrl_word[0];
  assign src         = ctrl_word[1];
  assign per_in      = ctrl_word[2];
  assign abort       = ctrl_word[3];
  assign unused_ctrl = ^ctrl_word[31:4];

  assign arm_edge = arm & ~arm_q;
  assign ext_edge = s2 & ~s3;

  // Effective period never shorter than pulse plus one low cycle.
  always_comb begin
    peff     = (period_q > P_MIN) ? period_q : P_MIN;
    peff_m1  = peff - P_ONE;
    pcnt_inc = pcnt + P_ONE;
    hit      = (pcnt_inc == peff_m1);
  end

  assign busy    = (state != IDLE);
  assign waiting = (state == WAIT_EXT);

  // Arm edge history and external sync synchronizer chain.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      arm_q <= 1'b1;
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
    end else begin
      arm_q <= arm;
      s1    <= ext_sync_in;
      s2    <= s1;
      s3    <= s2;
    end
  end

  // Sequencer: a pulse starts on the first FIRE cycle (wcnt == 0),
  // so entering FIRE one edge early gives exact P_eff spacing.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state      <= IDLE;
      sync_out   <= 1'b0;
      sync_count <= '0;
      pcnt       <= '0;
      wcnt       <= '0;
      per_mode   <= 1'b0;
      period_q   <= '0;
    end else if (abort) begin
      state    <= IDLE;
      sync_out <= 1'b0;
      pcnt     <= '0;
      wcnt     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (arm_edge) begin
            per_mode   <= per_in;
            period_q   <= period;
            sync_count <= '0;
            wcnt       <= '0;
            pcnt       <= '0;
            state      <= src ? WAIT_EXT : FIRE;
          end
        end
        WAIT_EXT: begin
          if (ext_edge) begin
            wcnt  <= '0;
            state <= FIRE;
          end
        end
        FIRE: begin
          if (wcnt == 8'd0) begin
            sync_out   <= 1'b1;
            sync_count <= sync_count + CNT_ONE;
            pcnt       <= '0;
            wcnt       <= 8'd1;
          end else if (wcnt == W_LAST) begin
            sync_out <= 1'b0;
            wcnt     <= '0;
            pcnt     <= pcnt_inc;
            if (!per_mode) begin
              state <= IDLE;
            end else if (hit) begin
              state <= FIRE;
            end else begin
              state <= PERIODIC;
            end
          end else begin
            wcnt <= wcnt + 8'd1;
            pcnt <= pcnt_inc;
          end
        end
        PERIODIC: begin
          pcnt <= pcnt_inc;
          if (hit) begin
            wcnt  <= '0;
            state <= FIRE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_gen_ctrl.sv
// tb_sync_gen_ctrl: scoreboard bench for sync_gen_ctrl.
// Instance a: SYNC_WIDTH=1, CNT_W=16. Instance b: SYNC_WIDTH=4, CNT_W=4.
module tb_sync_gen_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ctrl = 32'h1;
  logic [31:0] period = 32'd0;
  logic        ext = 1'b0;

  logic        sync_a, busy_a, wait_a;
  logic [15:0] cnt_a;
  logic        sync_b, busy_b, wait_b;
  logic [3:0]  cnt_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int rise_a[$];
  int wid_a[$];
  int rise_b[$];
  int wid_b[$];
  int exp_a[$];
  int expw_a[$];
  int exp_b[$];
  int expw_b[$];
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;
  int st_a = 0;
  int st_b = 0;

  sync_gen_ctrl #(
    .PERIOD_W(32), .SYNC_WIDTH(1), .CNT_W(16)
  ) u_a (
    .user_clk(clk), .user_rst(rst),
    .ctrl_word(ctrl), .period(period),
    .ext_sync_in(ext), .sync_out(sync_a),
    .busy(busy_a), .waiting(wait_a),
    .sync_count(cnt_a)
  );

  sync_gen_ctrl #(
    .PERIOD_W(32), .SYNC_WIDTH(4), .CNT_W(4)
  ) u_b (
    .user_clk(clk), .user_rst(rst),
    .ctrl_word(ctrl), .period(period),
    .ext_sync_in(ext), .sync_out(sync_b),
    .busy(busy_b), .waiting(wait_b),
    .sync_count(cnt_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: records rise cycle and width of every pulse.
  always @(negedge clk) begin
    if (sync_a && !prev_a) begin
      rise_a.push_back(cyc);
      st_a = cyc;
    end
    if (!sync_a && prev_a) wid_a.push_back(cyc - st_a);
    prev_a = sync_a;
    if (sync_b && !prev_b) begin
      rise_b.push_back(cyc);
      st_b = cyc;
    end
    if (!sync_b && prev_b) wid_b.push_back(cyc - st_b);
    prev_b = sync_b;
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    rise_a.delete(); wid_a.delete();
    rise_b.delete(); wid_b.delete();
    exp_a.delete(); expw_a.delete();
    exp_b.delete(); expw_b.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int c;
    int e;
    int o;
    ctrl = 32'h1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (sync_a !== 1'b0 || busy_a !== 1'b0 || wait_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got sync=%b busy=%b wait=%b, expected 0 0 0",
               sync_a, busy_a, wait_a);
    end
    checks++;
    if (cnt_a !== 16'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d, expected 0", cnt_a);
    end
    checks++;
    if (rise_a.size() != 0) begin
      errors++;
      $display("FAIL held_arm: got %0d pulses, expected 0", rise_a.size());
    end
    ctrl = 32'h0;
    @(negedge clk);
    c = cyc;
    ctrl = 32'h1;
    exp_a.push_back(c + 2);
    expw_a.push_back(1);
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b1 || sync_a !== 1'b0) begin
      errors++;
      $display("FAIL arm_busy: got busy=%b sync=%b, expected 1 0",
               busy_a, sync_a);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || cnt_a !== 16'd1) begin
      errors++;
      $display("FAIL oneshot_end: got busy=%b cnt=%0d, expected 0 1",
               busy_a, cnt_a);
    end
    repeat (4) @(negedge clk);
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      checks++;
      if (rise_a.size() == 0) begin
        errors++;
        $display("FAIL sw_rise: got none, expected cycle %0d", e);
      end else begin
        o = rise_a.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL sw_rise: got cycle %0d, expected %0d", o, e);
        end
      end
    end
    while (expw_a.size() > 0) begin
      e = expw_a.pop_front();
      checks++;
      o = (wid_a.size() > 0) ? wid_a.pop_front() : -1;
      if (o !== e) begin
        errors++;
        $display("FAIL sw_width: got %0d, expected %0d", o, e);
      end
    end
    checks++;
    if (rise_a.size() != 0) begin
      errors++;
      $display("FAIL sw_extra: got %0d extra pulses, expected 0",
               rise_a.size());
    end
  endtask

  task automatic test_external();
    int k0;
    int e;
    int o;
    do_reset();
    ctrl = 32'h0;
    @(negedge clk);
    ctrl = 32'h3;
    @(negedge clk);
    checks++;
    if (wait_a !== 1'b1 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL ext_wait: got wait=%b busy=%b, expected 1 1",
               wait_a, busy_a);
    end
    repeat (1000) @(negedge clk);
    checks++;
    if (rise_a.size() != 0 || wait_a !== 1'b1) begin
      errors++;
      $display("FAIL ext_hold: got %0d pulses wait=%b, expected 0 1",
               rise_a.size(), wait_a);
    end
    @(negedge clk);
    k0 = cyc;
    #2 ext = 1'b1;
    exp_a.push_back(k0 + 4);
    expw_a.push_back(1);
    repeat (3) @(negedge clk);
    checks++;
    if (wait_a !== 1'b0 || sync_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL ext_fire: got wait=%b sync=%b busy=%b, expected 0 0 1",
               wait_a, sync_a, busy_a);
    end
    @(negedge clk);
    checks++;
    if (sync_a !== 1'b1 || cnt_a !== 16'd1) begin
      errors++;
      $display("FAIL ext_pulse: got sync=%b cnt=%0d, expected 1 1",
               sync_a, cnt_a);
    end
    repeat (4) @(negedge clk);
    ext = 1'b0;
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      checks++;
      o = (rise_a.size() > 0) ? rise_a.pop_front() : -1;
      if (o !== e) begin
        errors++;
        $display("FAIL ext_rise: got cycle %0d, expected %0d", o, e);
      end
    end
    while (expw_a.size() > 0) begin
      e = expw_a.pop_front();
      checks++;
      o = (wid_a.size() > 0) ? wid_a.pop_front() : -1;
      if (o !== e) begin
        errors++;
        $display("FAIL ext_width: got %0d, expected %0d", o, e);
      end
    end
  endtask

  task automatic test_periodic();
    int c;
    int e;
    int o;
    do_reset();
    period = 32'd10;
    ctrl = 32'h0;
    @(negedge clk);
    c = cyc;
    ctrl = 32'h5;
    for (int i = 0; i < 20; i++) exp_a.push_back(c + 2 + 10 * i);
    repeat (192) @(negedge clk);
    checks++;
    if (cnt_a !== 16'd20) begin
      errors++;
      $display("FAIL per_count: got %0d, expected 20", cnt_a);
    end
    ctrl = 32'h8;
    @(negedge clk);
    period = 32'd0;
    ctrl = 32'h0;
    @(negedge clk);
    c = cyc;
    ctrl = 32'h5;
    for (int i = 0; i < 5; i++) exp_a.push_back(c + 2 + 2 * i);
    repeat (10) @(negedge clk);
    ctrl = 32'h8;
    repeat (4) @(negedge clk);
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      checks++;
      o = (rise_a.size() > 0) ? rise_a.pop_front() : -1;
      if (o !== e) begin
        errors++;
        $display("FAIL per_rise: got cycle %0d, expected %0d", o, e);
      end
    end
    checks++;
    if (rise_a.size() != 0) begin
      errors++;
      $display("FAIL per_extra: got %0d extra pulses, expected 0",
               rise_a.size());
    end
    ctrl = 32'h0;
  endtask

  task automatic test_abort();
    int c;
    int e;
    int o;
    do_reset();
    period = 32'd12;
    ctrl = 32'h0;
    @(negedge clk);
    c = cyc;
    ctrl = 32'h5;
    exp_b.push_back(c + 2);
    exp_b.push_back(c + 14);
    expw_b.push_back(4);
    expw_b.push_back(2);
    repeat (15) @(negedge clk);
    checks++;
    if (sync_b !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: got sync=%b, expected 1", sync_b);
    end
    ctrl = 32'h8;
    @(negedge clk);
    checks++;
    if (sync_b !== 1'b0 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL abort_cut: got sync=%b busy=%b, expected 0 0",
               sync_b, busy_b);
    end
    ctrl = 32'h9;
    @(negedge clk);
    checks++;
    if (busy_b !== 1'b0) begin
      errors++;
      $display("FAIL abort_arm: got busy=%b, expected 0", busy_b);
    end
    repeat (3) @(negedge clk);
    ctrl = 32'h1;
    repeat (20) @(negedge clk);
    checks++;
    if (cnt_b !== 4'd2 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL abort_keep: got cnt=%0d busy=%b, expected 2 0",
               cnt_b, busy_b);
    end
    while (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      checks++;
      o = (rise_b.size() > 0) ? rise_b.pop_front() : -1;
      if (o !== e) begin
        errors++;
        $display("FAIL abort_rise: got cycle %0d, expected %0d", o, e);
      end
    end
    while (expw_b.size() > 0) begin
      e = expw_b.pop_front();
      checks++;
      o = (wid_b.size() > 0) ? wid_b.pop_front() : -1;
      if (o !== e) begin
        errors++;
        $display("FAIL abort_width: got %0d, expected %0d", o, e);
      end
    end
    checks++;
    if (rise_b.size() != 0) begin
      errors++;
      $display("FAIL abort_extra: got %0d extra pulses, expected 0",
               rise_b.size());
    end
    ctrl = 32'h0;
  endtask

  task automatic test_back_to_back();
    int c;
    int d;
    int e;
    int o;
    do_reset();
    period = 32'd20;
    ctrl = 32'h0;
    @(negedge clk);
    c = cyc;
    ctrl = 32'h5;
    exp_a.push_back(c + 2);
    exp_a.push_back(c + 22);
    exp_a.push_back(c + 42);
    repeat (10) @(negedge clk);
    period = 32'd50;
    ctrl = 32'h0;
    @(negedge clk);
    ctrl = 32'h5;
    repeat (32) @(negedge clk);
    ctrl = 32'h8;
    @(negedge clk);
    ctrl = 32'h0;
    @(negedge clk);
    d = cyc;
    ctrl = 32'h5;
    exp_a.push_back(d + 2);
    exp_a.push_back(d + 52);
    repeat (2) @(negedge clk);
    checks++;
    if (cnt_a !== 16'd1) begin
      errors++;
      $display("FAIL rearm_count: got %0d, expected 1", cnt_a);
    end
    repeat (50) @(negedge clk);
    checks++;
    if (cnt_a !== 16'd2) begin
      errors++;
      $display("FAIL rearm_count2: got %0d, expected 2", cnt_a);
    end
    ctrl = 32'h8;
    repeat (3) @(negedge clk);
    while (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      checks++;
      o = (rise_a.size() > 0) ? rise_a.pop_front() : -1;
      if (o !== e) begin
        errors++;
        $display("FAIL b2b_rise: got cycle %0d, expected %0d", o, e);
      end
    end
    checks++;
    if (rise_a.size() != 0) begin
      errors++;
      $display("FAIL b2b_extra: got %0d extra pulses, expected 0",
               rise_a.size());
    end
    ctrl = 32'h0;
  endtask

  task automatic test_async_reset_wrap();
    int c;
    int e;
    int o;
    do_reset();
    period = 32'd0;
    ctrl = 32'h0;
    @(negedge clk);
    ctrl = 32'h5;
    repeat (3) @(negedge clk);
    checks++;
    if (sync_b !== 1'b1 || cnt_b !== 4'd1) begin
      errors++;
      $display("FAIL rst_pre: got sync=%b cnt=%0d, expected 1 1",
               sync_b, cnt_b);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (sync_b !== 1'b0 || busy_b !== 1'b0 || cnt_b !== 4'd0) begin
      errors++;
      $display("FAIL rst_async: got sync=%b busy=%b cnt=%0d, expected 0 0 0",
               sync_b, busy_b, cnt_b);
    end
    checks++;
    if (busy_a !== 1'b0 || cnt_a !== 16'd0) begin
      errors++;
      $display("FAIL rst_async_a: got busy=%b cnt=%0d, expected 0 0",
               busy_a, cnt_a);
    end
    do_reset();
    ctrl = 32'h0;
    @(negedge clk);
    c = cyc;
    ctrl = 32'h5;
    for (int i = 0; i < 17; i++) exp_b.push_back(c + 2 + 5 * i);
    repeat (77) @(negedge clk);
    checks++;
    if (cnt_b !== 4'd0) begin
      errors++;
      $display("FAIL wrap16: got %0d, expected 0", cnt_b);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (cnt_b !== 4'd1) begin
      errors++;
      $display("FAIL wrap17: got %0d, expected 1", cnt_b);
    end
    ctrl = 32'h8;
    repeat (4) @(negedge clk);
    while (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      checks++;
      o = (rise_b.size() > 0) ? rise_b.pop_front() : -1;
      if (o !== e) begin
        errors++;
        $display("FAIL wrap_rise: got cycle %0d, expected %0d", o, e);
      end
    end
    ctrl = 32'h0;
  endtask

  initial begin
    test_reset();
    test_external();
    test_periodic();
    test_abort();
    test_back_to_back();
    test_async_reset_wrap();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
